hazard_forward_unit: RTL and testbench

- Pipeline control block that consumes the decoded instruction stream feeding the ID/EXE pipeline register.
- Keeps its own shadow scoreboard of in-flight destinations in the EXE, MEM and WB stages.
- From that scoreboard it generates:
  - a load-use stall and bubble-insert request back toward IF/ID and ID/EXE;
  - a flush request on a taken branch;
  - forwarding selects for the EXE-stage ALU operands.

---
 rtl/hazard_forward_unit_pkg.sv | 21 ++
 rtl/hazard_scoreboard.sv | 71 +++++++
 rtl/hazard_forward_unit.sv | 117 +++++++++++
 tb/tb_hazard_forward_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding unit: operand-source selects,
// control FSM states and the forwarding priority helper.
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // MEM is the younger producer, so it wins over WB.
    function automatic logic [1:0] fwd_select(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow scoreboard of the EXE/MEM/WB destinations plus the slot-match
// logic for load-use detection and operand forwarding.
module hazard_scoreboard #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic             we_id,
    input  logic             load_id,
    output logic             load_use,
    output logic             mem_hit_a,
    output logic             wb_hit_a,
    output logic             mem_hit_b,
    output logic             wb_hit_b
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             load;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             rs1_used;
        logic             rs2_used;
    } slot_t;

    slot_t id_slot, exe, mem, wb;

    // Writes to x0 never mark a slot valid, so x0 can never create a hazard.
    always_comb begin
        id_slot          = '0;
        id_slot.valid    = we_id & (rd_id != '0);
        id_slot.rd       = rd_id;
        id_slot.load     = load_id;
        id_slot.rs1      = rs1_id;
        id_slot.rs2      = rs2_id;
        id_slot.rs1_used = rs1_used_id;
        id_slot.rs2_used = rs2_used_id;
    end

    // NOTE: sequential state uses non-blocking assignments so the three slots
    // shift as one register stage instead of collapsing within a single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe <= '0;
            mem <= '0;
            wb  <= '0;
        end else begin
            wb  <= mem;
            mem <= exe;
            exe <= issue ? id_slot : '0;
        end
    end

    assign load_use = exe.valid & exe.load &
                      ((rs1_used_id & (rs1_id != '0) & (rs1_id == exe.rd)) |
                       (rs2_used_id & (rs2_id != '0) & (rs2_id == exe.rd)));

    // A load still in MEM has no data yet, so it is excluded from MEM forwarding.
    assign mem_hit_a = exe.rs1_used & (exe.rs1 != '0) & mem.valid & ~mem.load & (mem.rd == exe.rs1);
    assign wb_hit_a  = exe.rs1_used & (exe.rs1 != '0) & wb.valid & (wb.rd == exe.rs1);
    assign mem_hit_b = exe.rs2_used & (exe.rs2 != '0) & mem.valid & ~mem.load & (mem.rd == exe.rs2);
    assign wb_hit_b  = exe.rs2_used & (exe.rs2 != '0) & wb.valid & (wb.rd == exe.rs2);

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: load-use stall/bubble, taken-branch flush FSM,
// EXE operand forwarding selects and a saturating stall counter.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1Used_id,
    input  logic             rs2Used_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic             registerWriteEnable_id,
    input  logic             regSelect_id,
    input  logic             branchTaken_exe,
    output logic             stall_if_o,
    output logic             bubble_idexe_o,
    output logic             flush_ifid_o,
    output logic [1:0]       fwdA_o,
    output logic [1:0]       fwdB_o,
    output logic [CNT_W-1:0] stallCount_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_t          state, state_next;
    logic [FC_W-1:0] flush_cnt, flush_cnt_next;
    logic [CNT_W-1:0] stall_count;
    logic            load_use, issue;
    logic            mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;

    assign issue = ~stall_if_o & ~bubble_idexe_o;

    hazard_scoreboard #(.REG_W(REG_W)) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst),
        .issue       (issue),
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1Used_id),
        .rs2_used_id (rs2Used_id),
        .rd_id       (rd_id),
        .we_id       (registerWriteEnable_id),
        .load_id     (regSelect_id),
        .load_use    (load_use),
        .mem_hit_a   (mem_hit_a),
        .wb_hit_a    (wb_hit_a),
        .mem_hit_b   (mem_hit_b),
        .wb_hit_b    (wb_hit_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        stall_if_o     = 1'b0;
        bubble_idexe_o = 1'b0;
        flush_ifid_o   = 1'b0;
        case (state)
            ST_RUN: begin
                if (branchTaken_exe) begin
                    flush_ifid_o   = 1'b1;
                    bubble_idexe_o = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_next     = ST_FLUSH;
                        flush_cnt_next = FC_W'(FLUSH_CYCLES - 1);
                    end
                end else if (load_use) begin
                    stall_if_o     = 1'b1;
                    bubble_idexe_o = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_ifid_o   = 1'b1;
                bubble_idexe_o = 1'b1;
                flush_cnt_next = flush_cnt - 1'b1;
                if (flush_cnt == FC_W'(1)) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
        // Outputs read zero for as long as reset is held, even with a branch on the input.
        if (!rst) begin
            stall_if_o     = 1'b0;
            bubble_idexe_o = 1'b0;
            flush_ifid_o   = 1'b0;
        end
    end

    assign fwdA_o = fwd_select(mem_hit_a, wb_hit_a);
    assign fwdB_o = fwd_select(mem_hit_b, wb_hit_b);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall_if_o && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign stallCount_o = stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed hazard scenarios
// followed by random instruction streams against an in-order pipeline model.
module tb_hazard_forward_unit;

    localparam int REG_W        = 5;
    localparam int FLUSH_CYCLES = 3;
    localparam int CNT_W        = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic             rs1Used_id = 1'b0, rs2Used_id = 1'b0;
    logic             registerWriteEnable_id = 1'b0, regSelect_id = 1'b0;
    logic             branchTaken_exe = 1'b0;
    logic             stall_if_o, bubble_idexe_o, flush_ifid_o;
    logic [1:0]       fwdA_o, fwdB_o;
    logic [CNT_W-1:0] stallCount_o;

    hazard_forward_unit #(
        .REG_W(REG_W), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rs1_id                 (rs1_id),
        .rs2_id                 (rs2_id),
        .rs1Used_id             (rs1Used_id),
        .rs2Used_id             (rs2Used_id),
        .rd_id                  (rd_id),
        .registerWriteEnable_id (registerWriteEnable_id),
        .regSelect_id           (regSelect_id),
        .branchTaken_exe        (branchTaken_exe),
        .stall_if_o             (stall_if_o),
        .bubble_idexe_o         (bubble_idexe_o),
        .flush_ifid_o           (flush_ifid_o),
        .fwdA_o                 (fwdA_o),
        .fwdB_o                 (fwdB_o),
        .stallCount_o           (stallCount_o)
    );

    always #5 clk = ~clk;

    // Reference model: the instructions currently occupying EXE, MEM and WB.
    typedef struct {
        bit v; int rd; bit ld; int rs1; int rs2; bit u1; bit u2;
    } instr_t;

    instr_t m_exe, m_mem, m_wb;
    int     m_flush_left;
    int     m_count;
    bit     e_stall, e_bubble, e_flush;
    int     e_fwd_a, e_fwd_b;
    int     n_vec  = 0;
    int     n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int fwd_of(input int src, input bit used);
        if (!used || src == 0)                      return 0;
        if (m_mem.v && !m_mem.ld && m_mem.rd == src) return 1;
        if (m_wb.v && m_wb.rd == src)               return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_exe = '{default: 0};
        m_mem = '{default: 0};
        m_wb  = '{default: 0};
        m_flush_left = 0;
        m_count      = 0;
        e_stall      = 1'b0;
        e_bubble     = 1'b0;
        e_flush      = 1'b0;
    endtask

    // Compare every output against the model in the middle of the cycle.
    task automatic eval();
        bit lu, fl;
        @(negedge clk);
        lu = m_exe.v && m_exe.ld &&
             ((rs1Used_id && rs1_id != 0 && int'(rs1_id) == m_exe.rd) ||
              (rs2Used_id && rs2_id != 0 && int'(rs2_id) == m_exe.rd));
        fl = (m_flush_left > 0) || branchTaken_exe;
        e_flush  = fl;
        e_bubble = fl || lu;
        e_stall  = !fl && lu;
        e_fwd_a  = fwd_of(m_exe.rs1, m_exe.u1);
        e_fwd_b  = fwd_of(m_exe.rs2, m_exe.u2);
        check("stall",  32'(stall_if_o),     32'(e_stall));
        check("bubble", 32'(bubble_idexe_o), 32'(e_bubble));
        check("flush",  32'(flush_ifid_o),   32'(e_flush));
        check("fwdA",   32'(fwdA_o),         32'(e_fwd_a));
        check("fwdB",   32'(fwdB_o),         32'(e_fwd_b));
        check("count",  32'(stallCount_o),   32'(m_count));
    endtask

    task automatic adv();
        @(posedge clk);
        m_wb  = m_mem;
        m_mem = m_exe;
        if (!e_stall && !e_bubble)
            m_exe = '{v: registerWriteEnable_id && rd_id != 0, rd: int'(rd_id), ld: regSelect_id,
                      rs1: int'(rs1_id), rs2: int'(rs2_id), u1: rs1Used_id, u2: rs2Used_id};
        else
            m_exe = '{default: 0};
        if (m_flush_left > 0)     m_flush_left--;
        else if (branchTaken_exe) m_flush_left = FLUSH_CYCLES - 1;
        if (e_stall && m_count < CNT_MAX) m_count++;
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic set_id(input logic [REG_W-1:0] rs1, input logic u1,
                          input logic [REG_W-1:0] rs2, input logic u2,
                          input logic [REG_W-1:0] rd, input logic we, input logic ld);
        rs1_id = rs1; rs1Used_id = u1;
        rs2_id = rs2; rs2Used_id = u2;
        rd_id  = rd;  registerWriteEnable_id = we; regSelect_id = ld;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst_stall",  32'(stall_if_o),     32'd0);
        check("rst_bubble", 32'(bubble_idexe_o), 32'd0);
        check("rst_flush",  32'(flush_ifid_o),   32'd0);
        check("rst_fwdA",   32'(fwdA_o),         32'd0);
        check("rst_fwdB",   32'(fwdB_o),         32'd0);
        check("rst_count",  32'(stallCount_o),   32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        apply_reset();

        // ALU -> ALU forwarding: MEM source first, then WB source.
        set_id(0, 0, 0, 0, 5, 1, 0); step();
        set_id(5, 1, 0, 0, 0, 0, 0); step();
        set_id(0, 0, 5, 1, 0, 0, 0);
        eval(); check("alu_fwdA_mem", 32'(fwdA_o), 32'd1); adv();
        set_id(0, 0, 0, 0, 0, 0, 0);
        eval(); check("alu_fwdB_wb", 32'(fwdB_o), 32'd2); adv();

        // Load-use: one stall cycle, then WB forwarding on rs2.
        set_id(0, 0, 0, 0, 7, 1, 1); step();
        set_id(0, 0, 7, 1, 3, 1, 0);
        eval(); check("lu_stall", 32'(stall_if_o), 32'd1); adv();
        eval(); check("lu_stall_once", 32'(stall_if_o), 32'd0); adv();
        set_id(0, 0, 0, 0, 0, 0, 0);
        eval();
        check("lu_fwdB_wb", 32'(fwdB_o), 32'd2);
        check("lu_count", 32'(stallCount_o), 32'd1);
        adv();

        // x0 immunity.
        set_id(0, 0, 0, 0, 0, 1, 1); step();
        set_id(0, 1, 0, 0, 0, 0, 0);
        eval(); check("x0_stall", 32'(stall_if_o), 32'd0); adv();
        eval(); check("x0_fwdA", 32'(fwdA_o), 32'd0); adv();

        // Taken branch beats load-use, then flush held for FLUSH_CYCLES.
        set_id(0, 0, 0, 0, 7, 1, 1); step();
        set_id(7, 1, 0, 0, 0, 0, 0); branchTaken_exe = 1'b1;
        eval(); check("br_lu_stall", 32'(stall_if_o), 32'd0); check("br_lu_flush", 32'(flush_ifid_o), 32'd1); adv();
        branchTaken_exe = 1'b0;
        for (int i = 1; i < FLUSH_CYCLES; i++) begin
            eval(); check("br_hold_flush", 32'(flush_ifid_o), 32'd1); adv();
        end
        eval(); check("br_release", 32'(flush_ifid_o), 32'd0); check("br_count", 32'(stallCount_o), 32'd1); adv();

        // Saturation: five more load-use stalls.
        for (int i = 0; i < 5; i++) begin
            set_id(0, 0, 0, 0, 7, 1, 1); step();
            set_id(7, 1, 0, 0, 0, 0, 0); step(); step();
        end
        set_id(0, 0, 0, 0, 0, 0, 0);
        eval(); check("sat_count", 32'(stallCount_o), 32'(CNT_MAX)); adv();

        // Reset mid-stream with a load to x7 in EXE and a consumer in ID.
        set_id(0, 0, 0, 0, 7, 1, 1); step();
        set_id(7, 1, 0, 0, 0, 0, 0);
        #1; check("pre_rst_stall", 32'(stall_if_o), 32'd1);
        apply_reset();
        eval(); check("post_rst_stall", 32'(stall_if_o), 32'd0); adv();

        // Random instruction stream; a stalled ID instruction is held.
        for (int i = 0; i < 400; i++) begin
            if (!e_stall) begin
                rs1_id = REG_W'($urandom_range(0, 7));
                rs2_id = REG_W'($urandom_range(0, 7));
                rd_id  = REG_W'($urandom_range(0, 7));
                rs1Used_id = 1'($urandom_range(0, 1));
                rs2Used_id = 1'($urandom_range(0, 1));
                registerWriteEnable_id = 1'($urandom_range(0, 3) != 0);
                regSelect_id = 1'($urandom_range(0, 2) == 0);
            end
            branchTaken_exe = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
